// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate unit: op codes, FSM states and op decode.
package shift_pkg;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  function automatic logic is_shift_op(input logic [4:0] op);
    return (op == OP_SHR) || (op == OP_SHRA) || (op == OP_SHL) ||
           (op == OP_ROR) || (op == OP_ROL);
  endfunction
endpackage

// File: rtl/seq_shift_unit_if.sv
// Request/response bundle of the shift unit; master drives the request side.
interface seq_shift_unit_if #(parameter int WIDTH = 32);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               start;
  logic [4:0]         op;
  logic [WIDTH-1:0]   operand;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic               illegal;

  modport master (output start, op, operand, shamt,
                  input  busy, done, result, illegal);
  modport slave  (input  start, op, operand, shamt,
                  output busy, done, result, illegal);
endinterface

// File: rtl/shift_step.sv
// Combinational single step: shifts/rotates val by k (0..STEP) according to op.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int KW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] val,
  input  logic [4:0]       op,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] res
);
  localparam int AW = $clog2(WIDTH) + 1;
  localparam logic [AW-1:0] WL = AW'(WIDTH);

  logic [AW-1:0] kx;
  logic [AW-1:0] kc;

  assign kx = AW'(k);
  // complement amount; k=0 gives a full-width shift which yields zero, so rotates stay exact
  assign kc = WL - kx;

  always_comb begin
    res = val;
    case (op)
      OP_SHR:  res = val >> kx;
      OP_SHRA: res = WIDTH'($signed(val) >>> kx);
      OP_SHL:  res = val << kx;
      OP_ROR:  res = (val >> kx) | (val << kc);
      OP_ROL:  res = (val << kx) | (val >> kc);
      default: res = val;
    endcase
  end
endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: STEP bits per clock, one-cycle done pulse, held result.
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic              clk,
  input  logic              clr,
  seq_shift_unit_if.slave   bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int KW      = $clog2(STEP + 1);
  localparam int AW      = $clog2(WIDTH) + 1;
  localparam logic [AW-1:0] STEP_X = AW'(STEP);

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [4:0]         op_q;
  logic [SHAMT_W-1:0] rem;
  logic [WIDTH-1:0]   result;
  logic               illegal;
  logic               busy;
  logic               done;

  logic [AW-1:0]      rem_x;
  logic [AW-1:0]      k_w;
  logic [WIDTH-1:0]   stepped;

  assign rem_x = AW'(rem);
  assign k_w   = (rem_x > STEP_X) ? STEP_X : rem_x;

  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) sh (
    .val (work),
    .op  (op_q),
    .k   (KW'(k_w)),
    .res (stepped)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      work    <= '0;
      op_q    <= '0;
      rem     <= '0;
      result  <= '0;
      illegal <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            work <= bus.operand;
            op_q <= bus.op;
            rem  <= bus.shamt;
            if (!is_shift_op(bus.op)) begin
              result  <= bus.operand;
              illegal <= 1'b1;
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= DONE;
            end else if (bus.shamt == '0) begin
              result  <= bus.operand;
              illegal <= 1'b0;
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= SHIFT;
            end
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          // start is deliberately not looked at here
          work <= stepped;
          rem  <= rem - SHAMT_W'(k_w);
          if (rem_x == k_w) begin
            result  <= stepped;
            illegal <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.result  = result;
  assign bus.illegal = illegal;
endmodule
